// File: rtl/fram_wr_queue.sv
// Write-request queue feeding the FRAM controller write port: buffers DEPTH cell writes, drains via req/grant/valid.
// Optional: define FRAM_WRQ_COALESCE_EN to merge a push into a queued entry with the same address.
module fram_wr_queue #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 6,
    parameter int unsigned DW    = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AW-1:0]          in_addr,
    input  logic [DW-1:0]          in_data,
    output logic                   mem_req,
    input  logic                   mem_grant,
    output logic                   mem_we,
    output logic [AW-1:0]          mem_addr,
    output logic [DW-1:0]          mem_wr_data,
    input  logic                   mem_valid,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full,
    output logic                   idle
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_BUSY, S_DONE} state_t;

    state_t        state_q;
    logic          mem_req_q;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic [AW-1:0] addr_mem_q [DEPTH];
    logic [DW-1:0] data_mem_q [DEPTH];
    logic          push, pop, alloc;
    logic [PW-1:0] wr_idx;

    assign push = in_valid && (count_q != FULL_CNT);
    assign pop  = (state_q == S_BUSY) && mem_valid;

`ifdef FRAM_WRQ_COALESCE_EN
    logic          hit;
    logic [PW-1:0] hit_idx;
    logic [PW-1:0] offs;

    // The head is in flight outside S_IDLE, so it must not absorb new data.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        offs    = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            offs = PW'(i) - rd_ptr_q;
            if (({1'b0, offs} < count_q) && !((offs == '0) && (state_q != S_IDLE))
                && (addr_mem_q[i] == in_addr)) begin
                hit     = 1'b1;
                hit_idx = PW'(i);
            end
        end
    end

    assign alloc  = push && !hit;
    assign wr_idx = hit ? hit_idx : wr_ptr_q;
`else
    assign alloc  = push;
    assign wr_idx = wr_ptr_q;
`endif

    always_comb begin
        wr_ptr_d = alloc ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop   ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (alloc && !pop) begin
            count_d = count_q + (PW+1)'(1);
        end else if (!alloc && pop) begin
            count_d = count_q - (PW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem_q[wr_idx] <= in_addr;
            data_mem_q[wr_idx] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            mem_req_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (count_q != '0) begin
                        state_q   <= S_REQ;
                        mem_req_q <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (mem_grant) begin
                        state_q <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (mem_valid) begin
                        state_q   <= S_DONE;
                        mem_req_q <= 1'b0;
                    end else if (!mem_grant) begin
                        state_q <= S_REQ;
                    end
                end
                S_DONE: begin
                    if (!mem_valid) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    // Head fields are gated so the outputs read zero whenever no request is active.
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_req_q;
    assign mem_addr    = mem_req_q ? addr_mem_q[rd_ptr_q] : '0;
    assign mem_wr_data = mem_req_q ? data_mem_q[rd_ptr_q] : '0;
    assign count       = count_q;
    assign empty       = (count_q == '0);
    assign full        = (count_q == FULL_CNT);
    assign in_ready    = (count_q != FULL_CNT);
    assign idle        = (count_q == '0) && (state_q == S_IDLE);

endmodule

// File: tb/tb_fram_wr_queue.sv
// Bench for fram_wr_queue: directed handshake scenarios plus a randomized run against a queue model.
// Coalescing expectations follow FRAM_WRQ_COALESCE_EN.
`timescale 1ns/1ps
module tb_fram_wr_queue;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned AW    = 6;
    localparam int unsigned DW    = 2;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_addr;
    logic [DW-1:0] in_data;
    logic          mem_req;
    logic          mem_grant;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wr_data;
    logic          mem_valid;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;
    logic          idle;

    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;

    fram_wr_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_addr    (in_addr),
        .in_data    (in_data),
        .mem_req    (mem_req),
        .mem_grant  (mem_grant),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wr_data(mem_wr_data),
        .mem_valid  (mem_valid),
        .count      (count),
        .empty      (empty),
        .full       (full),
        .idle       (idle)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input string nm);
        int unsigned w = 0;
        while (mem_req !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        n_cmp++;
        if (mem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_req_wait: mem_req=%b required 1 within 20 cycles", nm, mem_req);
        end
    endtask

    // Controller-side completion of one write, checking the presented head.
    task automatic serve(input logic [AW-1:0] ea, input logic [DW-1:0] ed, input string nm);
        wait_req(nm);
        n_cmp++;
        if ({mem_we, mem_addr, mem_wr_data} !== {1'b1, ea, ed}) begin
            n_fail++;
            $display("FAIL %s_head: we/addr/data=%b/%h/%b required 1/%h/%b", nm, mem_we, mem_addr, mem_wr_data, ea, ed);
        end
        mem_grant = 1'b1;
        tick();
        mem_valid = 1'b1;
        tick();
        mem_grant = 1'b0;
        mem_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        logic [17:0] exp_rst;
        exp_rst = {1'b1, 1'b0, 1'b0, 6'h00, 2'b00, 4'd0, 1'b1, 1'b0, 1'b1};
        rst_n = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0;
        mem_grant = 1'b0; mem_valid = 1'b0;
        tick(); tick();
        n_cmp++;
        if ({in_ready, mem_req, mem_we, mem_addr, mem_wr_data, count, empty, full, idle} !== exp_rst) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required %h",
                     {in_ready, mem_req, mem_we, mem_addr, mem_wr_data, count, empty, full, idle}, exp_rst);
        end
        rst_n = 1'b1;
        in_valid = 1'b1; in_addr = 6'h2A; in_data = 2'b11; tick();
        in_addr = 6'h2B; tick();
        in_valid = 1'b0;
        wait_req("midreset");
        mem_grant = 1'b1; tick();
        rst_n = 1'b0; in_valid = 1'b1; tick();
        n_cmp++;
        if ({in_ready, mem_req, mem_we, mem_addr, mem_wr_data, count, empty, full, idle} !== exp_rst) begin
            n_fail++;
            $display("FAIL midreset_outputs: got %h required %h",
                     {in_ready, mem_req, mem_we, mem_addr, mem_wr_data, count, empty, full, idle}, exp_rst);
        end
        rst_n = 1'b1; in_valid = 1'b0; mem_grant = 1'b0;
        tick(); tick(); tick();
        n_cmp++;
        if ({mem_req, count, idle} !== {1'b0, CW'(0), 1'b1}) begin
            n_fail++;
            $display("FAIL midreset_discard: req/count/idle=%b/%0d/%b required 0/0/1", mem_req, count, idle);
        end
    endtask

    task automatic test_single_write();
        in_valid = 1'b1; in_addr = 6'h15; in_data = 2'b10;
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if ({mem_req, count} !== {1'b0, CW'(1)}) begin
            n_fail++;
            $display("FAIL single_accept: req/count=%b/%0d required 0/1", mem_req, count);
        end
        tick();
        n_cmp++;
        if ({mem_req, mem_we, mem_addr, mem_wr_data} !== {1'b1, 1'b1, 6'h15, 2'b10}) begin
            n_fail++;
            $display("FAIL single_req: req/we/addr/data=%b/%b/%h/%b required 1/1/15/10", mem_req, mem_we, mem_addr, mem_wr_data);
        end
        mem_grant = 1'b1;
        tick();
        for (int i = 0; i < 9; i++) tick();
        n_cmp++;
        if ({mem_req, count} !== {1'b1, CW'(1)}) begin
            n_fail++;
            $display("FAIL single_busy: req/count=%b/%0d required 1/1", mem_req, count);
        end
        mem_valid = 1'b1;
        tick();
        n_cmp++;
        if ({mem_req, mem_we, count, empty, idle} !== {1'b0, 1'b0, CW'(0), 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL single_done: req/we/count/empty/idle=%b/%b/%0d/%b/%b required 0/0/0/1/0",
                     mem_req, mem_we, count, empty, idle);
        end
        mem_grant = 1'b0; mem_valid = 1'b0;
        tick();
        n_cmp++;
        if (idle !== 1'b1) begin
            n_fail++;
            $display("FAIL single_idle: idle=%b required 1", idle);
        end
    endtask

    task automatic test_fill_overflow();
        logic [DW-1:0] d [9];
        mem_grant = 1'b0;
        for (int i = 0; i < 9; i++) begin
            d[i] = DW'($urandom);
            in_valid = 1'b1; in_addr = AW'(i); in_data = d[i];
            tick();
            n_cmp++;
            if ({count, full, in_ready} !== {CW'(i < 8 ? i + 1 : 8), (i >= 7), (i < 7)}) begin
                n_fail++;
                $display("FAIL fill_%0d: count/full/ready=%0d/%b/%b required %0d/%b/%b",
                         i, count, full, in_ready, (i < 8 ? i + 1 : 8), (i >= 7), (i < 7));
            end
        end
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) serve(AW'(i), d[i], "fill_drain");
        for (int i = 0; i < 5; i++) tick();
        n_cmp++;
        if ({mem_req, count, idle} !== {1'b0, CW'(0), 1'b1}) begin
            n_fail++;
            $display("FAIL fill_no_ninth: req/count/idle=%b/%0d/%b required 0/0/1", mem_req, count, idle);
        end
    endtask

    task automatic test_collision();
        logic [AW-1:0] a [4];
        logic [DW-1:0] d [4];
        for (int i = 0; i < 4; i++) begin
            a[i] = AW'(8 * i + 1);
            d[i] = DW'($urandom);
        end
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_addr = a[i]; in_data = d[i];
            tick();
        end
        in_valid = 1'b0;
        wait_req("collide");
        mem_grant = 1'b1; tick();
        mem_valid = 1'b1; in_valid = 1'b1; in_addr = a[3]; in_data = d[3];
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if ({count, mem_req} !== {CW'(3), 1'b0}) begin
            n_fail++;
            $display("FAIL collide_count: count/req=%0d/%b required 3/0", count, mem_req);
        end
        mem_grant = 1'b0; mem_valid = 1'b0;
        tick();
        for (int i = 1; i < 4; i++) serve(a[i], d[i], "collide_drain");
    endtask

    task automatic test_grant_withdrawn();
        in_valid = 1'b1; in_addr = 6'h33; in_data = 2'b01;
        tick();
        in_valid = 1'b0;
        wait_req("withdraw");
        mem_grant = 1'b1; tick();
        mem_grant = 1'b0; tick();
        n_cmp++;
        if ({mem_req, count, mem_addr, mem_wr_data} !== {1'b1, CW'(1), 6'h33, 2'b01}) begin
            n_fail++;
            $display("FAIL withdraw_retain: req/count/addr/data=%b/%0d/%h/%b required 1/1/33/01",
                     mem_req, count, mem_addr, mem_wr_data);
        end
        // Without a grant the block is re-requesting, so a stray valid is not a completion.
        mem_valid = 1'b1; tick();
        mem_valid = 1'b0; tick();
        n_cmp++;
        if ({mem_req, count} !== {1'b1, CW'(1)}) begin
            n_fail++;
            $display("FAIL withdraw_rereq: req/count=%b/%0d required 1/1", mem_req, count);
        end
        mem_grant = 1'b1; tick(); tick();
        n_cmp++;
        if ({mem_req, mem_addr, mem_wr_data} !== {1'b1, 6'h33, 2'b01}) begin
            n_fail++;
            $display("FAIL withdraw_regrant: req/addr/data=%b/%h/%b required 1/33/01", mem_req, mem_addr, mem_wr_data);
        end
        mem_valid = 1'b1; tick();
        mem_grant = 1'b0; mem_valid = 1'b0; tick();
        n_cmp++;
        if ({count, idle} !== {CW'(0), 1'b1}) begin
            n_fail++;
            $display("FAIL withdraw_done: count/idle=%0d/%b required 0/1", count, idle);
        end
    endtask

    task automatic test_stale_valid();
        in_valid = 1'b1; in_addr = 6'h0A; in_data = 2'b11; tick();
        in_addr = 6'h0B; in_data = 2'b10; tick();
        in_valid = 1'b0;
        wait_req("stale");
        mem_grant = 1'b1; tick();
        mem_valid = 1'b1; tick();
        mem_grant = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if ({mem_req, count} !== {1'b0, CW'(1)}) begin
                n_fail++;
                $display("FAIL stale_hold_%0d: req/count=%b/%0d required 0/1", i, mem_req, count);
            end
        end
        mem_valid = 1'b0; tick();
        n_cmp++;
        if (mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL stale_gap: mem_req=%b required 0", mem_req);
        end
        tick();
        n_cmp++;
        if ({mem_req, mem_addr, mem_wr_data} !== {1'b1, 6'h0B, 2'b10}) begin
            n_fail++;
            $display("FAIL stale_next: req/addr/data=%b/%h/%b required 1/0b/10", mem_req, mem_addr, mem_wr_data);
        end
        serve(6'h0B, 2'b10, "stale_drain");
    endtask

    task automatic test_coalesce();
        mem_grant = 1'b0;
        in_valid = 1'b1; in_addr = 6'h07; in_data = 2'b01; tick();
        in_data = 2'b11; tick();
        in_valid = 1'b0;
`ifdef FRAM_WRQ_COALESCE_EN
        n_cmp++;
        if (count !== CW'(1)) begin
            n_fail++;
            $display("FAIL coalesce_count: count=%0d required 1", count);
        end
        serve(6'h07, 2'b11, "coalesce_drain");
`else
        n_cmp++;
        if (count !== CW'(2)) begin
            n_fail++;
            $display("FAIL coalesce_count: count=%0d required 2", count);
        end
        serve(6'h07, 2'b01, "nocoalesce_first");
        serve(6'h07, 2'b11, "nocoalesce_second");
`endif
    endtask

    // Random producer and controller; the model is a FIFO of accepted writes.
    task automatic test_random();
        logic [AW+DW-1:0] mq [$];
        int unsigned phase = 0;
        int unsigned cnt   = 0;
        int unsigned wt    = 0;
        int unsigned seq   = 0;
        logic push_now, pop_now, v_edge;
        v_edge = 1'b0;
        mem_grant = 1'b0; mem_valid = 1'b0; in_valid = 1'b0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            n_cmp++;
            if ({count, empty, full, in_ready} !== {CW'(mq.size()), mq.size() == 0, mq.size() == DEPTH, mq.size() != DEPTH}) begin
                n_fail++;
                $display("FAIL rnd_occupancy cyc %0d: count/empty/full/ready=%0d/%b/%b/%b required count %0d",
                         cyc, count, empty, full, in_ready, mq.size());
            end
            n_cmp++;
            if (mem_we !== mem_req) begin
                n_fail++;
                $display("FAIL rnd_we cyc %0d: mem_we=%b required %b", cyc, mem_we, mem_req);
            end
            if (mem_req === 1'b1) begin
                n_cmp++;
                if (mq.size() == 0 || {mem_addr, mem_wr_data} !== mq[0]) begin
                    n_fail++;
                    $display("FAIL rnd_head cyc %0d: addr/data=%h/%b required model head (size %0d)",
                             cyc, mem_addr, mem_wr_data, mq.size());
                end
            end
            if (v_edge) begin
                wt = 0;
                n_cmp++;
                if (mem_req !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rnd_req_after_valid cyc %0d: mem_req=%b required 0", cyc, mem_req);
                end
            end else if (mq.size() != 0 && mem_req !== 1'b1) begin
                wt++;
                n_cmp++;
                if (wt > 1) begin
                    n_fail++;
                    $display("FAIL rnd_req_latency cyc %0d: mem_req=%b required 1", cyc, mem_req);
                end
            end else begin
                wt = 0;
            end

            in_valid = ($urandom_range(0, 99) < (((cyc / 250) % 2 == 1) ? 70 : 20));
`ifdef FRAM_WRQ_COALESCE_EN
            in_addr = AW'(seq);
`else
            in_addr = AW'($urandom);
`endif
            in_data  = DW'($urandom);
            push_now = in_valid && (mq.size() < DEPTH);
            pop_now  = 1'b0;
            case (phase)
                0: begin
                    if (mem_req === 1'b1) begin
                        mem_grant = 1'b1; cnt = $urandom_range(0, 4); phase = 1;
                    end
                end
                1: begin
                    if (cnt == 0) begin
                        mem_valid = 1'b1; pop_now = 1'b1; phase = 2;
                    end else if ($urandom_range(0, 5) == 0) begin
                        mem_grant = 1'b0; phase = 0;
                    end else begin
                        cnt--;
                    end
                end
                2: begin
                    mem_grant = 1'b0; cnt = $urandom_range(0, 3);
                    if (cnt == 0) begin
                        mem_valid = 1'b0; phase = 0;
                    end else begin
                        phase = 3;
                    end
                end
                default: begin
                    cnt--;
                    if (cnt == 0) begin
                        mem_valid = 1'b0; phase = 0;
                    end
                end
            endcase
            v_edge = mem_valid;
            tick();
            if (pop_now && mq.size() != 0) void'(mq.pop_front());
            if (push_now) begin
                mq.push_back({in_addr, in_data});
                seq++;
            end
        end
        in_valid = 1'b0; mem_grant = 1'b0; mem_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_fill_overflow();
        test_collision();
        test_grant_withdrawn();
        test_stale_valid();
        test_coalesce();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
